// File: rtl/wind_pkg.sv
// Shared constants, FSM state type and the sine-table generator for wind_synth.
package wind_pkg;

    localparam int ROM_DEPTH  = 256;
    localparam int IDX_W      = 8;
    localparam int LAT        = 7;
    localparam int MIN_CLKDIV = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // round(2047*sin(2*pi*(k+0.5)/1024)) in Q30 fixed point; Taylor series
    // converges well since the angle never exceeds pi/2.
    localparam longint PI_Q30 = 64'd3373259426;

    function automatic int sine_entry(input int k);
        longint x, x2, term, sum;
        x    = (PI_Q30 * longint'(2 * k + 1)) / 1024;
        x2   = (x * x) >>> 30;
        term = x;
        sum  = x;
        for (int n = 1; n < 12; n++) begin
            term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        return int'((sum * 2047 + (longint'(1) <<< 29)) >>> 30);
    endfunction

endpackage

// File: rtl/wind_synth_sine_qrom.sv
// Quarter-wave sine ROM with quadrant folding and a single registered read.
module sine_qrom
    import wind_pkg::*;
(
    input  logic        clock,
    input  logic [9:0]  ph,     // [9:8] quadrant, [7:0] quarter-wave index
    output logic [11:0] dout
);

    logic [11:0]      rom [ROM_DEPTH];
    logic [IDX_W-1:0] idx;

    for (genvar k = 0; k < ROM_DEPTH; k++) begin : g_rom
        localparam logic [11:0] ENTRY = 12'(sine_entry(k));
        assign rom[k] = ENTRY;
    end

    // Odd quadrants run the table backwards, the lower half-turn is negated.
    assign idx = ph[8] ? ~ph[7:0] : ph[7:0];

    always_ff @(posedge clock) begin
        dout <= ph[9] ? (12'd0 - rom[idx]) : rom[idx];
    end

endmodule

// File: rtl/wind_synth.sv
// Four-channel transducer burst generator: carrier phase plus speed-dependent
// per-channel offsets, shared sine ROM, amplitude scaling, strobed outputs.
module wind_synth
    import wind_pkg::*;
#(
    parameter int CLKDIV = 10,
    parameter int KSPD   = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] nsamp,
    input  logic [15:0] phinc,
    input  logic [15:0] speedX,
    input  logic [15:0] speedY,
    input  logic [8:0]  amp,
    output logic [11:0] rx1,
    output logic [11:0] rx2,
    output logic [11:0] rx3,
    output logic [11:0] rx4,
    output logic        endata,
    output logic        busy,
    output logic        done
);

    localparam int DW = $clog2(CLKDIV);
    localparam logic signed [31:0] KS = 32'(KSPD);

    state_t            state, nstate;
    logic [DW-1:0]     div;
    logic [15:0]       cnt, acc;
    logic [15:0]       nsamp_q, phinc_q, offx, offy;
    logic [8:0]        amp_q;
    logic [3:0][15:0]  ph;
    logic [3:0][11:0]  stage;
    logic [1:0]        sel;
    logic [9:0]        rom_ph;
    logic [11:0]       rom_d;
    logic signed [31:0] prodx, prody;
    logic              accept, last_div, last_samp, run_upd;

    function automatic logic [11:0] scale(input logic [11:0] s, input logic [8:0] a);
        logic signed [21:0] p;
        p = 22'($signed(s)) * 22'($signed({1'b0, a}));
        return 12'(p >>> 8);
    endfunction

    assign prodx = $signed({{16{speedX[15]}}, speedX}) * KS;
    assign prody = $signed({{16{speedY[15]}}, speedY}) * KS;

    assign accept    = (state == IDLE) && start;
    assign last_div  = (div == DW'(CLKDIV - 1));
    assign last_samp = (cnt == nsamp_q - 16'd1);
    assign run_upd   = (state == RUN) && (div == DW'(LAT - 1));

    // Channel order rx1..rx4: Y downwind, X upwind, Y upwind, X downwind.
    assign ph[0] = acc + offy;
    assign ph[1] = acc;
    assign ph[2] = acc;
    assign ph[3] = acc + offx;

    // ROM is addressed for one channel per cycle at offsets 1..4.
    assign sel    = 2'(div - DW'(1));
    assign rom_ph = 10'(ph[sel] >> 6);

    sine_qrom u_rom (
        .clock (clock),
        .ph    (rom_ph),
        .dout  (rom_d)
    );

    always_comb begin
        nstate = state;
        case (state)
            IDLE: if (start) nstate = (nsamp == 16'd0) ? FIN : RUN;
            RUN:  if (last_div && last_samp) nstate = FIN;
            FIN:  nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= nstate;
    end

    assign busy = (state == RUN);
    assign done = (state == FIN);

    always_ff @(posedge clock) begin
        if (accept) begin
            nsamp_q <= nsamp;
            phinc_q <= phinc;
            amp_q   <= (amp > 9'd256) ? 9'd256 : amp;
            offx    <= 16'(prodx >>> 10);
            offy    <= 16'(prody >>> 10);
        end
        if (state == RUN && div >= DW'(2) && div <= DW'(LAT - 2))
            stage[2'(div - DW'(2))] <= rom_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc    <= '0;
            cnt    <= '0;
            div    <= '0;
            rx1    <= '0;
            rx2    <= '0;
            rx3    <= '0;
            rx4    <= '0;
            endata <= 1'b0;
        end else begin
            endata <= run_upd;
            if (accept) begin
                acc <= '0;
                cnt <= '0;
                div <= '0;
            end else if (state == RUN) begin
                div <= last_div ? '0 : div + DW'(1);
                if (last_div) begin
                    acc <= acc + phinc_q;
                    cnt <= cnt + 16'd1;
                end
            end
            if (run_upd) begin
                rx1 <= scale(stage[0], amp_q);
                rx2 <= scale(stage[1], amp_q);
                rx3 <= scale(stage[2], amp_q);
                rx4 <= scale(stage[3], amp_q);
            end
        end
    end

endmodule

// File: tb/tb_wind_synth.sv
// Directed bench for wind_synth: burst timing, channel values, scaling, start/reset corner cases.
module tb_wind_synth;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] nsamp = '0, phinc = '0, speedX = '0, speedY = '0;
    logic [8:0]  amp = '0;
    logic [11:0] rx1, rx2, rx3, rx4;
    logic        endata, busy, done;

    wind_synth #(.CLKDIV(10), .KSPD(1024)) dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .nsamp  (nsamp),
        .phinc  (phinc),
        .speedX (speedX),
        .speedY (speedY),
        .amp    (amp),
        .rx1    (rx1),
        .rx2    (rx2),
        .rx3    (rx3),
        .rx4    (rx4),
        .endata (endata),
        .busy   (busy),
        .done   (done)
    );

    always #5 clock = ~clock;

    int nasrt = 0;
    int nfail = 0;
    int ecyc[$], v1[$], v2[$], v3[$], v4[$];
    int done_cyc, ndone, nbusy, busy_first, busy_last;
    int snap[4];
    int snap_ctl;
    int quad[4] = '{6, 2047, -6, -2047};

    task automatic check(input string tag, input int obs, input int exp);
        nasrt++;
        assert (obs === exp)
        else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -99999;
    endfunction

    // Pulse start (cycle S = 0) then observe cycles S+1..S+ncyc. Inputs are
    // scrambled after acceptance and restored only for a deliberate re-start.
    task automatic burst(input int ns, input int ph, input int sx, input int sy, input int a,
                         input int ncyc, input int restart_at, input int reset_at,
                         input int snap_at);
        ecyc.delete(); v1.delete(); v2.delete(); v3.delete(); v4.delete();
        done_cyc = -1; ndone = 0; nbusy = 0; busy_first = -1; busy_last = -1;
        nsamp = 16'(ns); phinc = 16'(ph); speedX = 16'(sx); speedY = 16'(sy); amp = 9'(a);
        start = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clock); #2;
            start = 1'b0;
            reset = 1'b0;
            if (c == 1) begin
                nsamp = 16'd7; phinc = 16'h1234; speedX = 16'h0400; speedY = 16'hF000; amp = 9'd50;
            end
            if (c == restart_at) begin
                nsamp = 16'(ns); phinc = 16'(ph); speedX = 16'(sx); speedY = 16'(sy); amp = 9'(a);
                start = 1'b1;
            end
            if (c == reset_at) reset = 1'b1;
            if (endata) begin
                ecyc.push_back(c);
                v1.push_back(int'($signed(rx1)));
                v2.push_back(int'($signed(rx2)));
                v3.push_back(int'($signed(rx3)));
                v4.push_back(int'($signed(rx4)));
            end
            if (done) begin
                ndone++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (busy) begin
                nbusy++;
                if (busy_first < 0) busy_first = c;
                busy_last = c;
            end
            if (c == snap_at) begin
                snap[0] = int'($signed(rx1)); snap[1] = int'($signed(rx2));
                snap[2] = int'($signed(rx3)); snap[3] = int'($signed(rx4));
                snap_ctl = int'({endata, busy, done});
            end
        end
        start = 1'b0;
        reset = 1'b0;
    endtask

    task automatic check_basic(input string t);
        check({t, " n_endata"}, ecyc.size(), 4);
        for (int n = 0; n < 4; n++) begin
            check($sformatf("%s endata_cyc[%0d]", t, n), at(ecyc, n), 8 + 10 * n);
            check($sformatf("%s rx1[%0d]", t, n), at(v1, n), quad[n]);
            check($sformatf("%s rx2[%0d]", t, n), at(v2, n), quad[n]);
            check($sformatf("%s rx3[%0d]", t, n), at(v3, n), quad[n]);
            check($sformatf("%s rx4[%0d]", t, n), at(v4, n), quad[n]);
        end
        check({t, " done_cyc"}, done_cyc, 41);
        check({t, " n_done"}, ndone, 1);
        check({t, " busy_first"}, busy_first, 1);
        check({t, " busy_last"}, busy_last, 40);
        check({t, " n_busy"}, nbusy, 40);
        check({t, " rx1_hold"}, snap[0], -2047);
        check({t, " rx4_hold"}, snap[3], -2047);
    endtask

    initial begin
        // reset state
        repeat (3) @(posedge clock);
        #2;
        check("rst rx1", int'(rx1), 0);
        check("rst rx2", int'(rx2), 0);
        check("rst rx3", int'(rx3), 0);
        check("rst rx4", int'(rx4), 0);
        check("rst ctl", int'({endata, busy, done}), 0);
        reset = 1'b0;
        @(posedge clock); #2;

        // carrier quarter-turn steps, no wind
        burst(4, 16384, 0, 0, 256, 50, -1, -1, 48);
        check_basic("t1");

        // speed offsets: Y +1/4 turn, X -1/4 turn
        burst(1, 0, -16384, 16384, 256, 20, -1, -1, -1);
        check("t2 n_endata", ecyc.size(), 1);
        check("t2 rx1", at(v1, 0), 2047);
        check("t2 rx2", at(v2, 0), 6);
        check("t2 rx3", at(v3, 0), 6);
        check("t2 rx4", at(v4, 0), -2047);
        check("t2 done_cyc", done_cyc, 11);

        // half amplitude
        burst(2, 16384, 0, 0, 128, 30, -1, -1, -1);
        check("t3 n_endata", ecyc.size(), 2);
        check("t3 rx1[0]", at(v1, 0), 3);
        check("t3 rx3[0]", at(v3, 0), 3);
        check("t3 rx2[1]", at(v2, 1), 1023);
        check("t3 rx4[1]", at(v4, 1), 1023);
        check("t3 done_cyc", done_cyc, 21);

        // amplitude above unity clamps
        burst(2, 16384, 0, 0, 400, 30, -1, -1, -1);
        check("t4 rx1[0]", at(v1, 0), 6);
        check("t4 rx1[1]", at(v1, 1), 2047);
        check("t4 rx4[1]", at(v4, 1), 2047);

        // empty burst
        burst(0, 16384, 0, 0, 256, 12, -1, -1, -1);
        check("t5 done_cyc", done_cyc, 1);
        check("t5 n_done", ndone, 1);
        check("t5 n_endata", ecyc.size(), 0);
        check("t5 n_busy", nbusy, 0);

        // start while busy is ignored
        burst(3, 16384, 0, 0, 256, 50, 3, -1, -1);
        check("t6 n_endata", ecyc.size(), 3);
        check("t6 last_endata", at(ecyc, 2), 28);
        check("t6 done_cyc", done_cyc, 31);
        check("t6 n_done", ndone, 1);

        // start in the done cycle is ignored
        burst(1, 16384, 0, 0, 256, 30, 11, -1, -1);
        check("t7 n_endata", ecyc.size(), 1);
        check("t7 n_done", ndone, 1);

        // start right after done is accepted
        burst(1, 16384, 0, 0, 256, 30, 12, -1, -1);
        check("t8 n_endata", ecyc.size(), 2);
        check("t8 endata2_cyc", at(ecyc, 1), 20);
        check("t8 n_done", ndone, 2);

        // reset mid-burst between 2nd and 3rd strobe
        burst(4, 16384, 0, 0, 256, 60, -1, 20, 21);
        check("t9 n_endata", ecyc.size(), 2);
        check("t9 n_done", ndone, 0);
        check("t9 rx1", snap[0], 0);
        check("t9 rx2", snap[1], 0);
        check("t9 rx3", snap[2], 0);
        check("t9 rx4", snap[3], 0);
        check("t9 ctl", snap_ctl, 0);

        // fresh burst after the abort
        burst(4, 16384, 0, 0, 256, 50, -1, -1, 48);
        check_basic("t10");

        $display("End of test - %0d assertions evaluated, %0d failures", nasrt, nfail);
        $finish;
    end

endmodule

// File: doc/wind_synth.md
# wind_synth

Four-channel transducer-signal synthesizer that drives the wind receive chain in reverse. It takes a target wind velocity (speedX, speedY), generates a carrier burst, and applies per-channel phase offsets proportional to speed. It outputs rx1..rx4 samples with a 1-clock endata strobe, in the exact format the wind receiver consumes. It is used as the closed-loop stimulus source in simulation and for on-board self-test.

## Interface
Parameters:
- CLKDIV, 10: clock cycles per output sample; must be ≥ 8.
- KSPD, 1024: speed-to-phase gain. Phase offset in turns/65536 = (speed·KSPD) >>> 10.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  1-clock pulse; starts a burst; ignored while busy
- nsamp  in  16  number of samples in the burst, latched at start
- phinc  in  16  carrier phase increment per sample; 65536 = one turn; latched at start
- speedX  in  16 signed  X speed, 10 fractional bits; latched at start
- speedY  in  16 signed  Y speed, 10 fractional bits; latched at start
- amp  in  9  amplitude scale; 256 = unity; values > 256 are clamped to 256; latched at start
- rx1, rx2, rx3, rx4  out  12 signed  channel samples, registered
- endata  out  1  1-clock pulse; marks a new rx1..rx4 set
- busy  out  1  burst in progress
- done  out  1  1-clock pulse at burst end

## Operation
- FSM states:
  - IDLE: on start, latch inputs, clear the 16-bit accumulator acc and the sample count, then go to RUN. If nsamp == 0, go to FIN instead.
  - RUN: repeats one period of CLKDIV cycles per sample. When the last period completes, go to FIN.
  - FIN: pulse done, then return to IDLE.
- Offsets, computed once at start with a 32-bit product, low 16 bits kept (wrap):
  - offX = (speedX·KSPD) >>> 10
  - offY = (speedY·KSPD) >>> 10
- Per-sample channel phases, all mod 2^16:
  - rx1: acc + offY (Y downwind)
  - rx3: acc (Y upwind)
  - rx4: acc + offX (X downwind)
  - rx2: acc (X upwind)
- Sine lookup for phase p:
  - Quadrant q = p[15:14], index i = p[13:6].
  - ROM entry r[k] = round(2047·sin(2π(k+0.5)/1024)) for k = 0..255.
  - q0 → r[i]; q1 → r[255−i]; q2 → −r[i]; q3 → −r[255−i].
- Scaling: out = (s·amp) >>> 8, arithmetic shift, 12-bit result. No saturation is needed because |s| ≤ 2047 and amp ≤ 256.
- One shared registered ROM serves the four channels in sequence. Results collect in staging registers, and rx1..rx4 update simultaneously.
- acc += phinc after each sample.

## Timing
- Start accepted at cycle S. Sample n (0-based) period begins at cycle S+1+n·CLKDIV.
- Within a period:
  - offset 0: channel phases formed
  - offsets 1–4: ROM addressed for rx1, rx2, rx3, rx4
  - offsets 2–5: ROM data returned
  - offset 6: scale
  - offset 7: rx1..rx4 update and endata is high
- Latency start → first endata: 8 cycles. Then one endata every CLKDIV cycles.
- busy is high in cycles S+1 … S+nsamp·CLKDIV. done pulses at S+nsamp·CLKDIV+1, with busy low.
- nsamp == 0: busy never rises; done pulses at S+1.
- rx1..rx4 hold their last values between strobes and after the burst.
- start while busy or during FIN: ignored. start in the same cycle done pulses: ignored. start is accepted again from the cycle after done.
- Input changes during a burst have no effect.
- Reset (any state, including mid-burst): rx1..rx4 = 0, endata = 0, busy = 0, done = 0, acc = 0, state IDLE, all from the next edge. No done pulse is produced for an aborted burst.

## Structure
- Shared package wind_pkg holds:
  - ROM depth (256) and quarter-wave index width (8)
  - the pipeline offset constant LAT = 7
  - the FSM state enum
  - the minimum CLKDIV (8)
- Sub-module sine_qrom: 256×12 quarter-wave ROM with 1-cycle registered read and quadrant folding. The entries are generated from the formula above.
- Top level: FSM, period counter, accumulator, offset multipliers, amplitude multiplier, staging registers.

## Test plan
- phinc = 16384, speeds 0, amp = 256, nsamp = 4 → four endata pulses 10 cycles apart, the first at S+8; all channels read 6, 2047, −6, −2047; done at S+41.
- speedY = 16384, speedX = −16384, phinc = 0, amp = 256, nsamp = 1 → rx1 = 2047, rx3 = 6, rx4 = −2047, rx2 = 6.
- amp = 128, phinc = 16384, nsamp = 2 → values 3, 1023; amp = 400 → same as amp = 256.
- nsamp = 0 → done at S+1, no endata, busy stays 0. A second start at S+3 while a 3-sample burst is running → ignored, exactly 3 endata pulses.
- Reset asserted between the 2nd and 3rd endata → next cycle all outputs are 0, no further endata, no done. A new start then behaves as in the first test.
- Loopback into the wind receiver with speedX = 2048, speedY = −1024 → receiver speedX/speedY settle to within ±1 LSB of the ideal value for the chosen KSPD.
